// File: rtl/capsense_scanner.sv
// capsense_scanner: round-robin discharge/charge-time scanner for capacitive pads with hysteresis touch detect.
// Optional CAPSENSE_FILTER_EN: stores a 1/4-step IIR-filtered count instead of the raw count.
module capsense_scanner #(
  parameter int NUM_SENSE = 4,
  parameter int CNT_W = 16,
  parameter int DISCHARGE_CYC = 64,
  parameter int unsigned TIMEOUT = 'hFFFF,
  localparam int SW = NUM_SENSE > 1 ? $clog2(NUM_SENSE) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [CNT_W-1:0]     threshold,
  input  logic [CNT_W-1:0]     hysteresis,
  input  logic [NUM_SENSE-1:0] sense_in,
  output logic [NUM_SENSE-1:0] sense_oe,
  input  logic [SW-1:0]        rd_sel,
  output logic [CNT_W-1:0]     rd_count,
  output logic [NUM_SENSE-1:0] touched,
  output logic [NUM_SENSE-1:0] timeout,
  output logic                 scan_done
);
  localparam logic [2:0] IDLE = 3'd0, DISCHARGE = 3'd1, CHARGE = 3'd2, STORE = 3'd3, NEXT = 3'd4;
  localparam int DW = $clog2(DISCHARGE_CYC + 1);
  logic [2:0] state;
  logic [SW-1:0] ch;
  logic [DW-1:0] dcnt;
  logic [CNT_W-1:0] cnt, sval;
  logic flag, set_t, clr_t, last;
  logic [NUM_SENSE-1:0] s1, sync_in;
  logic [CNT_W-1:0] count [NUM_SENSE];
  assign sense_oe = state == CHARGE ? ~(NUM_SENSE'(1) << ch) : '1;
  assign rd_count = count[rd_sel];
  assign last = ch == SW'(NUM_SENSE - 1);
`ifdef CAPSENSE_FILTER_EN
  logic [NUM_SENSE-1:0] seed;
  logic signed [CNT_W:0] diff, filt;
  // Filtered value always lies between old and new count, so truncation is lossless.
  always_comb begin
    diff = $signed({1'b0, cnt}) - $signed({1'b0, count[ch]});
    filt = $signed({1'b0, count[ch]}) + (diff >>> 2);
    sval = seed[ch] ? CNT_W'(filt) : cnt;
  end
`else
  assign sval = cnt;
`endif
  assign set_t = !touched[ch] && ({1'b0, sval} > ({1'b0, threshold} + {1'b0, hysteresis}));
  assign clr_t = touched[ch] && (sval < threshold);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ch <= '0;
      dcnt <= '0;
      cnt <= '0;
      flag <= 1'b0;
      s1 <= '0;
      sync_in <= '0;
      touched <= '0;
      timeout <= '0;
      scan_done <= 1'b0;
      for (int i = 0; i < NUM_SENSE; i++) count[i] <= '0;
`ifdef CAPSENSE_FILTER_EN
      seed <= '0;
`endif
    end else begin
      s1 <= sense_in;
      sync_in <= s1;
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          ch <= '0;
          dcnt <= '0;
          if (enable) state <= DISCHARGE;
        end
        DISCHARGE: begin
          if (!enable) begin
            state <= IDLE;
            ch <= '0;
            dcnt <= '0;
          end else if (dcnt == DW'(DISCHARGE_CYC - 1)) begin
            dcnt <= '0;
            cnt <= '0;
            flag <= 1'b0;
            state <= CHARGE;
          end else dcnt <= dcnt + 1'b1;
        end
        CHARGE: begin
          // A rising pad wins over a simultaneous timeout: the count is still valid.
          if (!enable) begin
            state <= IDLE;
            ch <= '0;
          end else if (sync_in[ch]) state <= STORE;
          else if (cnt == CNT_W'(TIMEOUT)) begin
            flag <= 1'b1;
            state <= STORE;
          end else cnt <= cnt + 1'b1;
        end
        STORE: begin
          count[ch] <= sval;
          timeout[ch] <= flag;
          touched[ch] <= set_t ? 1'b1 : clr_t ? 1'b0 : touched[ch];
`ifdef CAPSENSE_FILTER_EN
          seed[ch] <= 1'b1;
`endif
          state <= NEXT;
        end
        NEXT: begin
          scan_done <= last;
          ch <= (last || !enable) ? '0 : ch + 1'b1;
          state <= enable ? DISCHARGE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_capsense_scanner.sv
// tb_capsense_scanner: table-driven, random and corner-case checks of capsense_scanner against a rule-level model.
module tb_capsense_scanner;
  localparam int N = 4, TO = 100;
  logic clk = 0, reset_n = 0, enable = 0;
  logic [15:0] threshold = 16'd30, hysteresis = 16'd5;
  logic [3:0] sense_in, sense_oe, touched, timeout;
  logic [1:0] rd_sel = 2'd0;
  logic [15:0] rd_count;
  logic scan_done;
  int checks = 0, failures = 0, done_cnt = 0, exp_done = 0;
  int k [N] = '{0, 0, 0, 0};
  int rel [N] = '{0, 0, 0, 0};
  int m_cnt [N];
  bit m_tch [N], m_to [N], m_seed [N];

  capsense_scanner #(.NUM_SENSE(N), .CNT_W(16), .DISCHARGE_CYC(4), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .threshold(threshold), .hysteresis(hysteresis),
    .sense_in(sense_in), .sense_oe(sense_oe), .rd_sel(rd_sel), .rd_count(rd_count),
    .touched(touched), .timeout(timeout), .scan_done(scan_done));

  always #5 clk = ~clk;

  // Pad model: reads high k cycles after release, k < 0 means held low.
  always @(posedge clk) for (int i = 0; i < N; i++) rel[i] <= sense_oe[i] ? 0 : rel[i] + 1;
  always_comb for (int i = 0; i < N; i++) sense_in[i] = !sense_oe[i] && k[i] >= 0 && rel[i] >= k[i];

  always @(posedge clk) if (scan_done) done_cnt <= done_cnt + 1;

  always @(negedge clk) begin
    checks++;
    if ($countones(~sense_oe) > 1) begin
      failures++;
      $display("FAIL onehot_oe actual=%b expected=at most one low bit", sense_oe);
    end
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic void model_pad(int i, int kk, int thr, int hys);
    int raw;
    m_to[i] = kk < 0 || kk + 2 > TO;
    raw = m_to[i] ? TO : kk + 2;
`ifdef CAPSENSE_FILTER_EN
    m_cnt[i] = m_seed[i] ? m_cnt[i] + ((raw - m_cnt[i]) >>> 2) : raw;
    m_seed[i] = 1;
`else
    m_cnt[i] = raw;
`endif
    if (!m_tch[i] && m_cnt[i] > thr + hys) m_tch[i] = 1;
    else if (m_tch[i] && m_cnt[i] < thr) m_tch[i] = 0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      m_tch[i] = 0;
      m_to[i] = 0;
      m_seed[i] = 0;
    end
  endfunction

  task automatic compare_all(string tag);
    for (int i = 0; i < N; i++) begin
      rd_sel = 2'(i);
      #1;
      check($sformatf("%s count[%0d]", tag, i), rd_count, m_cnt[i]);
      check($sformatf("%s touched[%0d]", tag, i), touched[i], m_tch[i]);
      check($sformatf("%s timeout[%0d]", tag, i), timeout[i], m_to[i]);
    end
  endtask

  task automatic run_scan(string tag);
    int n = 0;
    for (int i = 0; i < N; i++) model_pad(i, k[i], threshold, hysteresis);
    exp_done++;
    do begin
      @(negedge clk);
      n++;
    end while (!scan_done && n < 3000);
    check({tag, " scan_done_seen"}, n < 3000, 1);
    compare_all(tag);
    @(negedge clk);
    check({tag, " scan_done_width"}, scan_done, 0);
    check({tag, " scan_done_count"}, done_cnt, exp_done);
  endtask

  task automatic wait_oe(logic [3:0] pat, bit eq, string tag);
    int n = 0;
    while ((eq ? sense_oe != pat : sense_oe == pat) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " wait_bound"}, n < 1000, 1);
  endtask

  typedef struct {
    int k [N];
    int cnt [N];
    logic [3:0] tch;
    logic [3:0] to;
  } vec_t;
  vec_t tv [7];

  initial begin
    int r, base;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    check("reset sense_oe", sense_oe, 4'b1111);
    check("reset scan_done", scan_done, 0);
    reset_n = 1;
    repeat (10) @(negedge clk);
    check("idle sense_oe", sense_oe, 4'b1111);
    check("idle scan_done_count", done_cnt, 0);
`ifdef CAPSENSE_FILTER_EN
    k = '{38, 5, 5, 5};
    enable = 1;
    run_scan("filt1");
    rd_sel = 2'd0;
    #1 check("filt1 raw_seed", rd_count, 40);
    k[0] = 78;
    run_scan("filt2");
    rd_sel = 2'd0;
    #1 check("filt2 filtered", rd_count, 50);
`else
    tv[0].k = '{10, 20, 30, 40}; tv[0].cnt = '{12, 22, 32, 42};  tv[0].tch = 4'b1000; tv[0].to = 4'b0000;
    tv[1].k = '{32, 20, 30, 40}; tv[1].cnt = '{34, 22, 32, 42};  tv[1].tch = 4'b1000; tv[1].to = 4'b0000;
    tv[2].k = '{34, 20, 30, 40}; tv[2].cnt = '{36, 22, 32, 42};  tv[2].tch = 4'b1001; tv[2].to = 4'b0000;
    tv[3].k = '{30, 20, 30, 40}; tv[3].cnt = '{32, 22, 32, 42};  tv[3].tch = 4'b1001; tv[3].to = 4'b0000;
    tv[4].k = '{27, 20, 30, 40}; tv[4].cnt = '{29, 22, 32, 42};  tv[4].tch = 4'b1000; tv[4].to = 4'b0000;
    tv[5].k = '{27, 20, -1, 40}; tv[5].cnt = '{29, 22, 100, 42}; tv[5].tch = 4'b1100; tv[5].to = 4'b0100;
    tv[6].k = '{27, 20, 10, 40}; tv[6].cnt = '{29, 22, 12, 42};  tv[6].tch = 4'b1000; tv[6].to = 4'b0000;
    enable = 1;
    for (int v = 0; v < 7; v++) begin
      k = tv[v].k;
      run_scan($sformatf("vec%0d", v));
      for (int i = 0; i < N; i++) begin
        rd_sel = 2'(i);
        #1 check($sformatf("vec%0d tbl_count[%0d]", v, i), rd_count, tv[v].cnt[i]);
      end
      check($sformatf("vec%0d tbl_touched", v), touched, tv[v].tch);
      check($sformatf("vec%0d tbl_timeout", v), timeout, tv[v].to);
    end
`endif
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < N; i++) begin
        r = int'($urandom_range(0, 9));
        k[i] = r == 0 ? -1 : r == 1 ? int'($urandom_range(100, 130)) : int'($urandom_range(0, 95));
      end
      threshold = 16'($urandom_range(0, 120));
      hysteresis = 16'($urandom_range(0, 20));
      run_scan($sformatf("rnd%0d", s));
    end
    enable = 0;
    repeat (5) @(negedge clk);
    check("stop sense_oe", sense_oe, 4'b1111);
    k = '{5, 60, 5, 5};
    enable = 1;
    model_pad(0, k[0], threshold, hysteresis);
    wait_oe(4'b1101, 1, "abort");
    enable = 0;
    @(negedge clk);
    check("abort idle_oe", sense_oe, 4'b1111);
    base = done_cnt;
    repeat (30) @(negedge clk);
    check("abort no_scan_done", done_cnt, base);
    compare_all("abort");
    enable = 1;
    wait_oe(4'b1111, 0, "restart");
    check("restart pad0", sense_oe, 4'b1110);
    run_scan("restart");
    wait_oe(4'b1111, 0, "rst_mid");
    reset_n = 0;
    enable = 0;
    #1;
    model_reset();
    check("rst_mid sense_oe", sense_oe, 4'b1111);
    check("rst_mid scan_done", scan_done, 0);
    compare_all("rst_mid");
    @(negedge clk);
    reset_n = 1;
    repeat (5) @(negedge clk);
    check("post_rst idle_oe", sense_oe, 4'b1111);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/capsense_scanner.md
# capsense_scanner

Sequencer for the capacitive-sense pads on the DE0-Nano/Cramps hostmot2 build (four pads when capsense is enabled). Each pad is discharged by driving it low, then released, and the cycles until the pad reads high are counted. Counts are compared against a host threshold with hysteresis to give per-pad touched bits. Pads are scanned round-robin, one at a time. The scanner sits between the pad I/O buffers and the hm2 register file.

## Interface
Parameters:
- NUM_SENSE, 4, number of pads scanned (1..16)
- CNT_W, 16, width of the charge counter and of the per-pad count
- DISCHARGE_CYC, 64, number of cycles each pad is driven low before release (≥1)
- TIMEOUT, 16'hFFFF, maximum charge count, must be ≤ 2^CNT_W−1

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  runs scanning while high
- threshold  in  CNT_W  touch threshold
- hysteresis  in  CNT_W  hysteresis added to the threshold when setting a touch
- sense_in  in  NUM_SENSE  raw pad inputs (asynchronous)
- sense_oe  out  NUM_SENSE  1 = drive the pad low; the pad data value is tied to 0 externally
- rd_sel  in  $clog2(NUM_SENSE)  selects which count appears on rd_count
- rd_count  out  CNT_W  stored count of pad rd_sel, combinational mux
- touched  out  NUM_SENSE  debounced touch state per pad
- timeout  out  NUM_SENSE  last charge of that pad hit TIMEOUT
- scan_done  out  1  one-cycle pulse after the last pad is stored

## Operation
- sense_in passes through a 2-flop synchronizer (sync_in) before use.
- State machine states: IDLE, DISCHARGE, CHARGE, STORE, NEXT.
- IDLE:
  - sense_oe is all ones and the channel index ch is 0.
  - When enable is high, go to DISCHARGE.
- DISCHARGE:
  - sense_oe is all ones and dcnt counts from 0.
  - After DISCHARGE_CYC cycles, clear the charge counter and go to CHARGE.
- CHARGE:
  - sense_oe[ch] = 0; all other pads stay at 1.
  - Each cycle where sync_in[ch] = 0 and cnt < TIMEOUT, cnt increments.
  - Exit to STORE when sync_in[ch] = 1, with no increment that cycle.
  - Exit to STORE when cnt = TIMEOUT, and set a timeout flag.
- STORE:
  - Write count[ch] = cnt and timeout[ch] = flag.
  - Touch compare uses a CNT_W+1-bit sum, so it cannot overflow.
  - If touched[ch] = 0 and cnt > threshold + hysteresis, set touched[ch] = 1.
  - If touched[ch] = 1 and cnt < threshold, clear touched[ch] = 0.
  - Otherwise touched[ch] is unchanged.
- NEXT:
  - If ch = NUM_SENSE−1: pulse scan_done and wrap ch to 0.
  - Otherwise ch increments.
  - Then go to DISCHARGE if enable = 1, else IDLE.
- enable falling in DISCHARGE or CHARGE aborts to IDLE on the next edge. The current pad's count, touched and timeout are left unchanged, and scan_done is not pulsed.
- threshold and hysteresis are sampled only in STORE; host writes take effect at the next store.

## Timing
- Reset values:
  - state is IDLE.
  - sense_oe is all ones.
  - all counts, touched, timeout and scan_done are 0.
  - the synchronizer flops are 0.
- Per-pad cost: DISCHARGE_CYC + (cnt+1) + 1 (STORE) + 1 (NEXT) cycles.
- A pad that rises K cycles after release reports cnt = K+2, because of synchronizer latency.
- touched, timeout and count update on the edge leaving STORE.
- scan_done is high for exactly the one cycle following NEXT of the last pad.
- rd_count has zero latency and follows rd_sel combinationally.
- NUM_SENSE = 1: ch stays at 0 and scan_done pulses on every pad cycle.

## Configuration
- CAPSENSE_FILTER_EN defined:
  - STORE writes the filtered count count[ch] + ((cnt − count[ch]) >>> 2), using signed CNT_W+1 arithmetic.
  - Touch compare uses the filtered value.
  - The first store after reset loads cnt directly; one seed bit per pad tracks this.
- CAPSENSE_FILTER_EN undefined: raw cnt is stored and compared; no seed bits exist.

## Test plan
- Reset and idle:
  - Stimulus: reset_n low mid-CHARGE, enable = 0.
  - Required: all outputs return to reset values; sense_oe = 4'b1111 while idle.
- Single scan:
  - Stimulus: pad models rise 10, 20, 30, 40 cycles after release; DISCHARGE_CYC = 4.
  - Required: counts 12, 22, 32, 42; one scan_done pulse per scan; only one sense_oe bit low at a time.
- Hysteresis:
  - Stimulus: threshold = 30, hysteresis = 5; pad0 count sequence 34, 36, 32, 29.
  - Required: touched[0] reads 0, 1, 1, 0.
- Timeout:
  - Stimulus: TIMEOUT = 100, pad2 held low.
  - Required: count[2] = 100 and timeout[2] = 1; after pad2 recovers to rise at 10, timeout[2] = 0.
- Abort:
  - Stimulus: enable dropped during pad1 CHARGE.
  - Required: IDLE next cycle; count[1] unchanged; no scan_done; re-enable restarts at pad0.
- Filter (CAPSENSE_FILTER_EN):
  - Stimulus: pad0 raw counts 40 then 80.
  - Required: stored values 40 then 50.
